// File: rtl/fc1_weight_stream_ctrl.sv
// Streams OUT_DEPTH ROM rows repeat_count times onto a valid/ready beat interface.
// Credit-based read issue keeps the ROM pipeline plus the output FIFO from overflowing.
module fc1_weight_stream_ctrl #(
    parameter int OUT_SIZE    = 32,
    parameter int OUT_WIDTH   = 16,
    parameter int OUT_DEPTH   = 8,
    parameter int ROM_LATENCY = 2,
    parameter int FIFO_DEPTH  = 4,
    localparam int ADDR_WIDTH = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [15:0]                   repeat_count,
    output logic                          busy,
    output logic                          done,
    output logic [ADDR_WIDTH-1:0]         rom_addr,
    output logic                          rom_ce,
    input  logic [OUT_WIDTH*OUT_SIZE-1:0] rom_q,
    output logic [OUT_WIDTH-1:0]          data_out [OUT_SIZE-1:0],
    output logic                          data_out_valid,
    input  logic                          data_out_ready,
    output logic                          data_out_last
);

    localparam int WORD_W = OUT_WIDTH * OUT_SIZE;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

    generate
        if (ROM_LATENCY < 1 || FIFO_DEPTH < ROM_LATENCY + 1) begin : g_bad_params
            $error("fc1_weight_stream_ctrl: need ROM_LATENCY >= 1 and FIFO_DEPTH >= ROM_LATENCY+1");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                 state_reg, state_next;
    logic [ADDR_WIDTH-1:0]  addr_reg, addr_next;
    logic [15:0]            pass_reg, pass_next;
    logic [15:0]            rep_reg;
    logic                   done_zero_reg;

    logic [ROM_LATENCY-1:0] tag_reg, tag_next;
    logic [ROM_LATENCY-1:0] tag_last_reg, tag_last_next;

    logic [WORD_W-1:0]      fifo_data [FIFO_DEPTH];
    logic                   fifo_last [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]       count_reg;

    int                     inflight;
    logic                   credit_ok;
    logic                   issue;
    logic                   addr_last;
    logic                   fifo_wr;
    logic                   fifo_rd;
    logic                   drain_done;
    logic [WORD_W-1:0]      head_word;

    // Reads already in the ROM pipeline count against FIFO space before they land.
    always_comb begin
        inflight = 0;
        for (int i = 0; i < ROM_LATENCY; i++) begin
            inflight = inflight + int'(tag_reg[i]);
        end
    end

    assign credit_ok  = (int'(count_reg) + inflight) < FIFO_DEPTH;
    assign issue      = (state_reg == RUN) && credit_ok;
    assign addr_last  = (addr_reg == ADDR_WIDTH'(OUT_DEPTH - 1));
    assign fifo_wr    = tag_reg[ROM_LATENCY-1];
    assign fifo_rd    = data_out_valid && data_out_ready;
    assign drain_done = (state_reg == DRAIN) && (tag_reg == '0) && (count_reg == '0);

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        pass_next  = pass_reg;
        case (state_reg)
            IDLE: begin
                if (start && repeat_count != 16'd0) begin
                    state_next = RUN;
                    addr_next  = '0;
                    pass_next  = '0;
                end
            end
            RUN: begin
                if (issue) begin
                    if (addr_last) begin
                        addr_next = '0;
                        if (pass_reg == rep_reg - 16'd1) begin
                            state_next = DRAIN;
                        end else begin
                            pass_next = pass_reg + 16'd1;
                        end
                    end else begin
                        addr_next = addr_reg + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (drain_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            pass_reg      <= '0;
            rep_reg       <= '0;
            done_zero_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            pass_reg      <= pass_next;
            done_zero_reg <= (state_reg == IDLE) && start && (repeat_count == 16'd0);
            if (state_reg == IDLE && start) begin
                rep_reg <= repeat_count;
            end
        end
    end

    // Each tag travels alongside its ROM read; the last-row flag rides with it.
    assign tag_next[0]      = issue;
    assign tag_last_next[0] = issue && addr_last;
    genvar gi;
    generate
        for (gi = 1; gi < ROM_LATENCY; gi++) begin : g_tag
            assign tag_next[gi]      = tag_reg[gi-1];
            assign tag_last_next[gi] = tag_last_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_reg      <= '0;
            tag_last_reg <= '0;
        end else begin
            tag_reg      <= tag_next;
            tag_last_reg <= tag_last_next;
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            fifo_data[wr_ptr_reg] <= rom_q;
            fifo_last[wr_ptr_reg] <= tag_last_reg[ROM_LATENCY-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (fifo_wr) begin
                wr_ptr_reg <= (wr_ptr_reg == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (fifo_rd) begin
                rd_ptr_reg <= (rd_ptr_reg == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
            end
            case ({fifo_wr, fifo_rd})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Outputs are forced to zero when no beat is held, so stale FIFO words never leak out.
    assign data_out_valid = (count_reg != '0);
    assign head_word      = fifo_data[rd_ptr_reg];
    assign data_out_last  = data_out_valid && fifo_last[rd_ptr_reg];

    generate
        for (gi = 0; gi < OUT_SIZE; gi++) begin : g_unpack
            assign data_out[gi] = data_out_valid ? head_word[OUT_WIDTH*gi +: OUT_WIDTH] : '0;
        end
    endgenerate

    assign busy     = (state_reg != IDLE);
    assign rom_ce   = busy;
    assign rom_addr = addr_reg;
    assign done     = done_zero_reg || drain_done;

endmodule

// File: tb/tb_fc1_weight_stream_ctrl.sv
// Self-checking bench: ROM model with fixed latency, expected-beat queue scoreboard,
// and directed scenarios for latency, multi-pass streaming, stalls, zero count and reset abort.
module tb_fc1_weight_stream_ctrl;

    localparam int OUT_SIZE    = 32;
    localparam int OUT_WIDTH   = 16;
    localparam int OUT_DEPTH   = 8;
    localparam int ROM_LATENCY = 2;
    localparam int FIFO_DEPTH  = 4;
    localparam int ADDR_WIDTH  = 3;
    localparam int WORD_W      = OUT_SIZE * OUT_WIDTH;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  start = 1'b0;
    logic [15:0]           repeat_count = 16'd0;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic                  rom_ce;
    logic [WORD_W-1:0]     rom_q;
    logic [OUT_WIDTH-1:0]  data_out [OUT_SIZE-1:0];
    logic                  data_out_valid;
    logic                  data_out_ready = 1'b1;
    logic                  data_out_last;

    int checks = 0;
    int errors = 0;

    fc1_weight_stream_ctrl #(
        .OUT_SIZE   (OUT_SIZE),
        .OUT_WIDTH  (OUT_WIDTH),
        .OUT_DEPTH  (OUT_DEPTH),
        .ROM_LATENCY(ROM_LATENCY),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .repeat_count  (repeat_count),
        .busy          (busy),
        .done          (done),
        .rom_addr      (rom_addr),
        .rom_ce        (rom_ce),
        .rom_q         (rom_q),
        .data_out      (data_out),
        .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready),
        .data_out_last (data_out_last)
    );

    always #5 clk = ~clk;

    // Element j of ROM row a is 0xA000 + a*256 + j.
    function automatic logic [OUT_WIDTH-1:0] rom_elem(input int a, input int j);
        return OUT_WIDTH'(32'hA000 + a * 256 + j);
    endfunction

    function automatic logic [WORD_W-1:0] rom_word(input int a);
        logic [WORD_W-1:0] w;
        for (int j = 0; j < OUT_SIZE; j++) begin
            w[OUT_WIDTH*j +: OUT_WIDTH] = rom_elem(a, j);
        end
        return w;
    endfunction

    logic [WORD_W-1:0] rom_pipe [ROM_LATENCY];
    always @(posedge clk) begin
        if (rom_ce) begin
            rom_pipe[0] <= rom_word(int'(rom_addr));
            for (int i = 1; i < ROM_LATENCY; i++) begin
                rom_pipe[i] <= rom_pipe[i-1];
            end
        end
    end
    assign rom_q = rom_pipe[ROM_LATENCY-1];

    // Scoreboard: each accepted start appends the row addresses the stream must deliver.
    int exp_q[$];
    int exp_done   = 0;
    int done_cnt   = 0;
    int xfer_cnt   = 0;
    int first_xfer = -1;
    int last_xfer  = -1;
    int cyc        = 0;
    bit rand_mode  = 1'b0;
    bit ready_fixed = 1'b1;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            data_out_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_fixed;
        end
    end

    initial begin
        bit                   prev_stall = 1'b0;
        logic [OUT_WIDTH-1:0] prev_d0 = '0;
        logic [OUT_WIDTH-1:0] prev_dn = '0;
        logic                 prev_last = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (done) done_cnt++;
                if (prev_stall) begin
                    checks++;
                    if (!data_out_valid || data_out[0] != prev_d0 ||
                        data_out[OUT_SIZE-1] != prev_dn || data_out_last != prev_last) begin
                        errors++;
                        $display("FAIL stall_hold cyc=%0d actual valid=%b d0=%h last=%b required valid=1 d0=%h last=%b",
                                 cyc, data_out_valid, data_out[0], data_out_last, prev_d0, prev_last);
                    end
                end
                if (data_out_valid && data_out_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL beat_extra cyc=%0d actual d0=%h required no beat", cyc, data_out[0]);
                    end else begin
                        int a;
                        int bad;
                        a = exp_q.pop_front();
                        bad = -1;
                        for (int j = 0; j < OUT_SIZE; j++) begin
                            if (bad < 0 && data_out[j] != rom_elem(a, j)) bad = j;
                        end
                        if (bad >= 0 || data_out_last != (a == OUT_DEPTH - 1)) begin
                            errors++;
                            if (bad < 0) bad = 0;
                            $display("FAIL beat cyc=%0d elem=%0d actual data=%h last=%b required data=%h last=%b",
                                     cyc, bad, data_out[bad], data_out_last, rom_elem(a, bad), (a == OUT_DEPTH - 1));
                        end
                    end
                    if (first_xfer < 0) first_xfer = cyc;
                    last_xfer = cyc;
                    xfer_cnt++;
                end
                prev_stall = data_out_valid && !data_out_ready;
                prev_d0    = data_out[0];
                prev_dn    = data_out[OUT_SIZE-1];
                prev_last  = data_out_last;
            end
        end
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        xfer_cnt   = 0;
        first_xfer = -1;
        last_xfer  = -1;
    endtask

    // Drives start for one cycle (cycle T); returns 1ns into cycle T+1.
    task automatic do_start(input int rc);
        start        = 1'b1;
        repeat_count = 16'(rc);
        for (int k = 0; k < OUT_DEPTH * rc; k++) exp_q.push_back(k % OUT_DEPTH);
        exp_done++;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 1000) begin
            tick(1);
            n++;
        end
        check({name, "_timeout"}, int'(busy), 0);
        tick(1);
        check({name, "_queue_left"}, exp_q.size(), 0);
        check({name, "_done_count"}, done_cnt, exp_done);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        tick(3);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_rom_ce", int'(rom_ce), 0);
        check("rst_rom_addr", int'(rom_addr), 0);
        check("rst_valid", int'(data_out_valid), 0);
        check("rst_last", int'(data_out_last), 0);
        rst = 1'b0;
        tick(2);

        // Single pass, ready high: latency and literal first beat.
        clear_stats();
        do_start(1);
        check("s1_addr0", int'(rom_addr), 0);
        check("s1_busy", int'(busy), 1);
        check("s1_rom_ce", int'(rom_ce), 1);
        k = 1;
        while (!data_out_valid && k < 50) begin
            tick(1);
            k++;
        end
        check("s1_first_valid_offset", k, 2 + ROM_LATENCY);
        check("s1_first_elem5", int'(data_out[5]), 32'hA005);
        check("s1_first_last", int'(data_out_last), 0);
        wait_idle("s1");
        check("s1_beats", xfer_cnt, 8);
        check("s1_done_literal", done_cnt, 1);

        // Three passes, ready high: contiguous beats.
        clear_stats();
        do_start(3);
        wait_idle("s2");
        check("s2_beats", xfer_cnt, 24);
        check("s2_span", last_xfer - first_xfer, 23);

        // Random ready, two passes.
        clear_stats();
        rand_mode = 1'b1;
        do_start(2);
        wait_idle("s3");
        check("s3_beats", xfer_cnt, 16);
        rand_mode = 1'b0;
        ready_fixed = 1'b1;
        tick(2);

        // Ready low for 20 cycles: only FIFO_DEPTH reads may be issued.
        clear_stats();
        ready_fixed = 1'b0;
        tick(2);
        do_start(1);
        tick(20);
        check("s4_rom_addr_stalled", int'(rom_addr), FIFO_DEPTH);
        check("s4_valid_held", int'(data_out_valid), 1);
        check("s4_no_xfer", xfer_cnt, 0);
        check("s4_head_elem0", int'(data_out[0]), 32'hA000);
        ready_fixed = 1'b1;
        wait_idle("s4");
        check("s4_beats", xfer_cnt, 8);

        // Zero repeat count: done at T+1, no activity.
        do_start(0);
        check("s5_done", int'(done), 1);
        check("s5_busy", int'(busy), 0);
        check("s5_rom_ce", int'(rom_ce), 0);
        tick(1);
        check("s5_done_cleared", int'(done), 0);
        tick(1);
        check("s5_done_count", done_cnt, exp_done);

        // Reset at the 5th beat, then a fresh single pass.
        clear_stats();
        do_start(2);
        k = 0;
        while (xfer_cnt < 4 && k < 100) begin
            tick(1);
            k++;
        end
        check("s6_fifth_elem0", int'(data_out[0]), 32'hA400);
        rst = 1'b1;
        #1;
        exp_q.delete();
        exp_done--;
        check("s6_rst_valid", int'(data_out_valid), 0);
        check("s6_rst_busy", int'(busy), 0);
        check("s6_rst_rom_ce", int'(rom_ce), 0);
        check("s6_rst_rom_addr", int'(rom_addr), 0);
        check("s6_rst_data0", int'(data_out[0]), 0);
        check("s6_rst_last", int'(data_out_last), 0);
        tick(3);
        rst = 1'b0;
        tick(3);
        check("s6_no_stale_valid", int'(data_out_valid), 0);
        check("s6_no_done", done_cnt, exp_done);
        clear_stats();
        do_start(1);
        check("s6_restart_addr0", int'(rom_addr), 0);
        wait_idle("s6");
        check("s6_beats", xfer_cnt, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
